mem_stage: RTL and testbench

//  MIPS MEM pipeline stage; consumes the EXE->MEM register outputs and drives the data-memory req/ack port.

---
 rtl/mem_stage_pkg.sv | 55 +++++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: ALU_Control access
// encodings, FSM state encoding, access-size type and decode helpers.
package mem_stage_pkg;

  // ALU_Control encodings for memory accesses (MIPS major opcodes)
  localparam logic [5:0] ALU_LB  = 6'h20;
  localparam logic [5:0] ALU_LH  = 6'h21;
  localparam logic [5:0] ALU_LW  = 6'h23;
  localparam logic [5:0] ALU_LBU = 6'h24;
  localparam logic [5:0] ALU_LHU = 6'h25;
  localparam logic [5:0] ALU_SB  = 6'h28;
  localparam logic [5:0] ALU_SH  = 6'h29;
  localparam logic [5:0] ALU_SW  = 6'h2B;
  // A plain ALU operation, used by non-memory instructions
  localparam logic [5:0] ALU_ADD = 6'h02;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Access width implied by the op code; anything unrecognised is a word
  function automatic access_size_t op_size(input logic [5:0] op);
    access_size_t sz;
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: sz = SZ_BYTE;
      ALU_LH, ALU_LHU, ALU_SH: sz = SZ_HALF;
      default:                 sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Only LB and LH sign-extend; everything else is zero-extended
  function automatic logic op_signed(input logic [5:0] op);
    return (op == ALU_LB) || (op == ALU_LH);
  endfunction

  // Natural-alignment test on the low address bits
  function automatic logic misaligned(input access_size_t sz, input logic [1:0] addr_lo);
    logic bad;
    case (sz)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory port: extracts and
// extends load data from the read word, and places store data on the
// correct lanes with matching byte enables. Halfword lanes are chosen by
// addr[1] only and words ignore addr[1:0], so misaligned accesses truncate.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  access_size_t size,
  input  logic         sign_ext,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  rdata,
  input  logic [31:0]  store_data,
  output logic [31:0]  load_data,
  output logic [3:0]   be,
  output logic [31:0]  wdata
);

  // Physical lane numbers: byte lane 0 = bits[7:0], half lane 0 = bits[15:0]
  logic [1:0] byte_lane;
  logic       half_lane;
  logic [7:0] rbyte [4];
  logic [7:0] sel_byte;
  logic [15:0] sel_half;

  assign byte_lane = (BIG_ENDIAN != 0) ? ~addr_lo : addr_lo;
  assign half_lane = (BIG_ENDIAN != 0) ? ~addr_lo[1] : addr_lo[1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = rdata[8*gi +: 8];
      assign be[gi] = (size == SZ_WORD) ||
                      ((size == SZ_HALF) && (half_lane == 1'(gi / 2))) ||
                      ((size == SZ_BYTE) && (byte_lane == 2'(gi)));
    end
  endgenerate

  assign sel_byte = rbyte[byte_lane];
  assign sel_half = half_lane ? rdata[31:16] : rdata[15:0];

  // Load extraction with sign or zero extension
  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: load_data = rdata;
    endcase
  end

  // Store data is replicated across all lanes; byte enables pick the live ones
  always_comb begin
    wdata = store_data;
    case (size)
      SZ_BYTE: wdata = {4{store_data[7:0]}};
      SZ_HALF: wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM pipeline stage. Takes the EXE/MEM register outputs, runs the
// data-memory req/ack handshake, stalls the front of the pipe while an
// access is outstanding, and produces the MEM/WB register plus the two
// forwarding values. A watchdog aborts accesses that wait too long.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses are refused
// (no request, error pulse, bubble) instead of being issued with truncation.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BIG_ENDIAN  = 1,
  parameter int WDOG_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        STALL_OUT,
  output logic        MemError_OUT,
  output logic [31:0] Fwd_EXEMEM,
  output logic [31:0] Fwd_MEMWB,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT
);

  // Last permitted WAIT count; the abort fires when it is reached without ack
  localparam logic [15:0] WDOG_LAST = (WDOG_CYCLES > 0) ? 16'(WDOG_CYCLES - 1) : 16'd0;

  mem_state_t   state_reg;
  logic [15:0]  wdog_reg;

  logic         memop;
  logic         is_write;
  access_size_t size;
  logic         align_err;
  logic         access_go;
  logic         abort;
  logic         complete;
  logic         stall;
  logic [31:0]  load_data;
  logic [3:0]   lane_be;
  logic [31:0]  lane_wdata;

  // Both MemRead and MemWrite set is treated as a read
  assign memop    = MemRead1_IN | MemWrite1_IN;
  assign is_write = MemWrite1_IN & ~MemRead1_IN;
  assign size     = op_size(ALU_Control1_IN);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = memop & misaligned(size, ALU_result1_IN[1:0]);
`else
  assign align_err = 1'b0;
`endif

  assign access_go = memop & ~align_err;
  assign abort     = (WDOG_CYCLES != 0) && (state_reg == WAIT) &&
                     (wdog_reg == WDOG_LAST) && !dmem_ack;
  assign complete  = access_go & dmem_ack;
  assign stall     = access_go & ~dmem_ack & ~abort;

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .size      (size),
    .sign_ext  (op_signed(ALU_Control1_IN)),
    .addr_lo   (ALU_result1_IN[1:0]),
    .rdata     (dmem_rdata),
    .store_data(MemWriteData1_IN),
    .load_data (load_data),
    .be        (lane_be),
    .wdata     (lane_wdata)
  );

  assign dmem_req     = access_go;
  assign dmem_we      = access_go & is_write;
  assign dmem_addr    = {ALU_result1_IN[31:2], 2'b00};
  assign dmem_be      = access_go ? lane_be : 4'h0;
  assign dmem_wdata   = lane_wdata;
  assign STALL_OUT    = stall;
  assign MemError_OUT = abort | align_err;
  assign Fwd_EXEMEM   = ALU_result1_IN;
  assign Fwd_MEMWB    = WriteData1_OUT;

  // Access FSM and watchdog: enter WAIT on an unacknowledged request, leave on ack or abort
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      wdog_reg  <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          wdog_reg <= 16'd0;
          if (access_go && !dmem_ack) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // Dropping the request while waiting breaks the upstream hold
          // contract; fall back to IDLE rather than wait forever.
          if (dmem_ack || abort || !access_go) begin
            state_reg <= IDLE;
            wdog_reg  <= 16'd0;
          end else begin
            wdog_reg <= wdog_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          wdog_reg  <= 16'd0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled or on error, else pass or complete the access
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Instr1_OUT         <= 32'd0;
      Instr1_PC_OUT      <= 32'd0;
      WriteData1_OUT     <= 32'd0;
      WriteRegister1_OUT <= 5'd0;
      RegWrite1_OUT      <= 1'b0;
    end else if (stall || abort || align_err) begin
      Instr1_OUT         <= 32'd0;
      Instr1_PC_OUT      <= 32'd0;
      WriteData1_OUT     <= 32'd0;
      WriteRegister1_OUT <= 5'd0;
      RegWrite1_OUT      <= 1'b0;
    end else begin
      Instr1_OUT         <= Instr1_IN;
      Instr1_PC_OUT      <= Instr1_PC_IN;
      WriteRegister1_OUT <= WriteRegister1_IN;
      if (complete && !is_write) begin
        WriteData1_OUT <= load_data;
        RegWrite1_OUT  <= RegWrite1_IN;
      end else if (complete) begin
        WriteData1_OUT <= ALU_result1_IN;
        RegWrite1_OUT  <= 1'b0;
      end else begin
        WriteData1_OUT <= ALU_result1_IN;
        RegWrite1_OUT  <= RegWrite1_IN;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage (BIG_ENDIAN=1, WDOG_CYCLES=4). The driver acts as
// the pipeline and the data memory (a byte-addressed big-endian array); the
// expected MEM/WB result of each instruction is queued and a separate
// monitor compares it when the instruction shows up at the stage output.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int WDOG = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        STALL_OUT, MemError_OUT;
  logic [31:0] Fwd_EXEMEM, Fwd_MEMWB, Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic [4:0]  WriteRegister1_OUT;
  logic        RegWrite1_OUT;

  mem_stage #(.BIG_ENDIAN(1), .WDOG_CYCLES(WDOG)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .STALL_OUT(STALL_OUT), .MemError_OUT(MemError_OUT),
    .Fwd_EXEMEM(Fwd_EXEMEM), .Fwd_MEMWB(Fwd_MEMWB),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int n_txn  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [4:0]  wreg;
    logic        rw;
    logic        full;   // write data / dest reg are defined for this instruction
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] mem_b [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    return {mem_b[b], mem_b[b + 8'd1], mem_b[b + 8'd2], mem_b[b + 8'd3]};
  endfunction

  task automatic drive_idle();
    Instr1_IN = 0; Instr1_PC_IN = 0; ALU_result1_IN = 0; MemWriteData1_IN = 0;
    WriteRegister1_IN = 0; RegWrite1_IN = 0; ALU_Control1_IN = 0;
    MemRead1_IN = 0; MemWrite1_IN = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // One instruction through the stage; the memory acks 'delay' cycles after the request
  task automatic do_txn(input logic [5:0] op, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic regw, input logic [4:0] wreg, input int delay);
    logic mem, is_w, sgn, misal, align_err, go, abort, exp_stall, exp_err, last;
    int nbytes;
    logic [7:0] base;
    logic [31:0] ldv, wd_exp;
    logic [3:0] be_exp;
    exp_t e;
    mem  = rd | wr;
    is_w = wr & ~rd;
    nbytes = (op == ALU_LB || op == ALU_LBU || op == ALU_SB) ? 1 :
             (op == ALU_LH || op == ALU_LHU || op == ALU_SH) ? 2 : 4;
    sgn  = (op == ALU_LB) || (op == ALU_LH);
    misal = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
    align_err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    align_err = mem & misal;
`endif
    go    = mem & ~align_err;
    abort = go && (delay > WDOG);
    base  = addr[7:0] - 8'(int'(addr[7:0]) % nbytes);
    ldv = 0;
    be_exp = 0;
    for (int i = 0; i < nbytes; i++) begin
      ldv = (ldv << 8) | 32'(mem_b[8'(int'(base) + i)]);
      be_exp[3 - ((int'(base) + i) % 4)] = 1'b1;
    end
    if (sgn && ldv[8*nbytes-1]) ldv = ldv | ~((32'd1 << (8*nbytes)) - 32'd1);
    wd_exp = (nbytes == 1) ? {4{data[7:0]}} : (nbytes == 2) ? {2{data[15:0]}} : data;

    n_txn++;
    Instr1_IN = 32'hA000_0000 | 32'(n_txn);
    Instr1_PC_IN = 32'h0040_0000 + 32'(4 * n_txn);
    ALU_result1_IN = addr; MemWriteData1_IN = data; WriteRegister1_IN = wreg;
    RegWrite1_IN = regw; ALU_Control1_IN = op; MemRead1_IN = rd; MemWrite1_IN = wr;

    for (int c = 0; c <= WDOG; c++) begin
      dmem_ack   = go && (c == delay);
      dmem_rdata = dmem_ack ? word_at(addr) : $urandom;
      #2;
      exp_stall = go && (c < delay) && (c < WDOG);
      exp_err   = align_err || (go && c == WDOG && delay > WDOG);
      chk("stall", STALL_OUT, exp_stall);
      chk("mem_error", MemError_OUT, exp_err);
      chk("req", dmem_req, go);
      chk("fwd_exemem", Fwd_EXEMEM, addr);
      if (go) begin
        chk("addr", dmem_addr, {addr[31:2], 2'b00});
        chk("we", dmem_we, is_w);
        if (is_w) begin
          chk("be", dmem_be, be_exp);
          chk("wdata", dmem_wdata, wd_exp);
        end
      end
      last = !exp_stall;
      @(posedge CLK); #1;
      if (last) break;
    end

    if (go && is_w && !abort)
      for (int i = 0; i < nbytes; i++)
        mem_b[8'(int'(base) + i)] = 8'(data >> (8 * (nbytes - 1 - i)));

    if (!abort && !align_err) begin
      e.instr = Instr1_IN; e.pc = Instr1_PC_IN; e.wreg = wreg;
      e.rw   = (go && is_w) ? 1'b0 : regw;
      e.wd   = (go && !is_w) ? ldv : addr;
      e.full = !(go && is_w);
      sb_q.push_back(e);
    end

    if (abort) begin
      drive_idle();
      #2;
      chk("req_after_abort", dmem_req, 0);
      chk("stall_after_abort", STALL_OUT, 0);
      @(posedge CLK); #1;
    end
  endtask

  // Monitor: every valid instruction at the output is matched against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (Instr1_OUT != 32'd0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", Instr1_OUT, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("out_instr", Instr1_OUT, e.instr);
            chk("out_pc", Instr1_PC_OUT, e.pc);
            chk("out_regwrite", RegWrite1_OUT, e.rw);
            if (e.full) begin
              chk("out_wdata", WriteData1_OUT, e.wd);
              chk("out_wreg", WriteRegister1_OUT, e.wreg);
              chk("fwd_memwb", Fwd_MEMWB, e.wd);
            end
          end
        end else begin
          chk("bubble_regwrite", RegWrite1_OUT, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [5:0] OPS [9] = '{ALU_ADD, ALU_LB, ALU_LBU, ALU_LH, ALU_LHU,
                                     ALU_LW, ALU_SB, ALU_SH, ALU_SW};

  initial begin
    logic [5:0] op;
    logic rd, wr;
    logic [31:0] addr;
    int dly;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
    RESET = 1'b1;
    drive_idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_req", dmem_req, 0);
    chk("reset_stall", STALL_OUT, 0);
    chk("reset_err", MemError_OUT, 0);
    chk("reset_wdata", WriteData1_OUT, 0);
    chk("reset_regwrite", RegWrite1_OUT, 0);
    chk("reset_instr", Instr1_OUT, 0);
    RESET = 1'b0;

    // ADD passes straight through
    do_txn(ALU_ADD, 0, 0, 32'h0000_1234, 32'h0, 1, 5'd5, 0);
    // LW with a three-cycle ack
    {mem_b[8'h00], mem_b[8'h01], mem_b[8'h02], mem_b[8'h03]} = 32'hDEAD_BEEF;
    do_txn(ALU_LW, 1, 0, 32'h0000_0100, 32'h0, 1, 5'd8, 3);
    // LB / LBU at offset 1 of 0x11F23344
    {mem_b[8'h00], mem_b[8'h01], mem_b[8'h02], mem_b[8'h03]} = 32'h11F2_3344;
    do_txn(ALU_LB, 1, 0, 32'h0000_0101, 32'h0, 1, 5'd9, 0);
    do_txn(ALU_LBU, 1, 0, 32'h0000_0101, 32'h0, 1, 5'd10, 1);
    // SH to the low halfword lanes
    do_txn(ALU_SH, 0, 1, 32'h0000_0102, 32'h0000_ABCD, 1, 5'd11, 2);
    // Watchdog: never acked aborts; acked on the last allowed cycle completes
    do_txn(ALU_LW, 1, 0, 32'h0000_0110, 32'h0, 1, 5'd12, 1000);
    do_txn(ALU_LW, 1, 0, 32'h0000_0110, 32'h0, 1, 5'd13, WDOG);
    // Misaligned word store (refused only with the alignment check built in)
    do_txn(ALU_SW, 0, 1, 32'h0000_0101, 32'h1234_5678, 0, 5'd0, 0);

    // Reset in the middle of a wait, then a stray ack with no access pending
    n_txn++;
    Instr1_IN = 32'hA000_0000 | 32'(n_txn); Instr1_PC_IN = 32'h0040_0000;
    ALU_result1_IN = 32'h0000_0120; ALU_Control1_IN = ALU_LW;
    MemRead1_IN = 1; RegWrite1_IN = 1; WriteRegister1_IN = 5'd3; dmem_ack = 0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    drive_idle();
    @(posedge CLK); #1;
    chk("rst_wait_req", dmem_req, 0);
    chk("rst_wait_stall", STALL_OUT, 0);
    chk("rst_wait_instr", Instr1_OUT, 0);
    chk("rst_wait_regwrite", RegWrite1_OUT, 0);
    RESET = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #2;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", STALL_OUT, 0);
    @(posedge CLK); #1;
    dmem_ack = 1'b0;
    chk("late_ack_wdata", WriteData1_OUT, 0);
    chk("late_ack_regwrite", RegWrite1_OUT, 0);

    // Randomised mix of ALU ops, loads and stores
    for (int t = 0; t < 300; t++) begin
      op = OPS[$urandom_range(0, 8)];
      rd = (op == ALU_LB || op == ALU_LBU || op == ALU_LH || op == ALU_LHU || op == ALU_LW);
      wr = (op == ALU_SB || op == ALU_SH || op == ALU_SW);
      if (rd && $urandom_range(0, 15) == 0) wr = 1'b1;
      addr = (rd | wr) ? (32'h0000_0100 | 32'($urandom_range(0, 255))) : $urandom;
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      do_txn(op, rd, wr, addr, $urandom, 1'($urandom), 5'($urandom), dly);
    end

    drive_idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
